mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one single-port synchronous SRAM between the IF-stage instruction fetch and the MEM-stage load/store.
- This lets the pipeline run from a unified memory instead of separate IM and DM instances.
- Grants one access per cycle, routes read data back to its owner one cycle later, and drives per-requester stalls.
- Data has priority; a starvation counter guarantees fetch progress.

Parameters:
- AW, 16, SRAM byte-address width (matches SRAM address[15:0]).
- DW, 32, data width.
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request.
- i_addr  in  AW  fetch address.
- i_ready  out  1  fetch granted this cycle; the IF stage stalls when i_req=1 and i_ready=0.
- i_rvalid  out  1  fetch data valid this cycle.
- i_rdata  out  DW  fetch read data.
- d_req  in  1  data request.
- d_w_en  in  4  byte write enables; 0 means read.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_ready  out  1  data granted this cycle.
- d_rvalid  out  1  load data valid this cycle.
- d_rdata  out  DW  load read data.
- sram_w_en  out  4  to SRAM w_en.
- sram_addr  out  AW  to SRAM address.
- sram_wdata  out  DW  to SRAM write_data.
- sram_rdata  in  DW  from SRAM read_data; valid one cycle after address.

Behaviour:
- Reset: while rst=0 (asynchronous, active-low):
  - owner=NONE, starve_cnt=0, i_rvalid=0, d_rvalid=0.
  - i_ready and d_ready are forced 0.
  - sram_w_en=0.
- Grant decision is combinational in the same cycle; at most one grant per cycle.
  - force_i = (starve_cnt == STARVE_MAX).
  - i_req & d_req & !force_i -> grant D.
  - i_req & d_req & force_i -> grant I.
  - Only one requester asserts req -> grant it.
  - Neither -> no grant, sram_w_en=0, sram_addr holds the last driven value.
- SRAM drive:
  - Grant I: sram_addr=i_addr, sram_w_en=0.
  - Grant D: sram_addr=d_addr, sram_w_en=d_w_en, sram_wdata=d_wdata.
- Read return, 1-cycle latency:
  - owner register captures I (fetch grant), D (data read grant, d_w_en==0) or NONE (write or no grant).
  - Next cycle: i_rvalid = (owner==I), d_rvalid = (owner==D).
  - i_rdata = d_rdata = sram_rdata, unregistered pass-through.
- Writes produce no rvalid; the write commits at the grant edge.
- Back-to-back grants every cycle give full throughput.
- starve_cnt (4 bit), on each clock edge:
  - i_req & !i_ready -> increment, saturating at STARVE_MAX.
  - Otherwise -> 0.
- Boundaries:
  - STARVE_MAX reached -> exactly one forced fetch grant, then the counter clears.
  - Requester drops req mid-stall -> no grant; no state other than starve_cnt is kept.
  - Reset asserted while a read is in flight -> the pending rvalid is discarded and never appears after reset release.
  - Requesters must hold addr/w_en/wdata stable until ready; unchanged req/addr with ready=0 is a legal retry.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined:
  - Adds output conflict_cnt, 32 bit.
  - Increments on every cycle with i_req & d_req & rst=1, saturating at 0xFFFF_FFFF.
  - Reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package mem_arb_pkg:
  - owner_e enum (NONE=2'd0, I=2'd1, D=2'd2).
  - Default AW/DW constants.
  - STARVE_CNT_W=4.
- One sub-module, arb_starve_cnt: saturating starvation counter with force output.
- All remaining logic stays flat in mem_arbiter.

Test Plan:
- Reset/idle: rst=0 with i_req=d_req=1 -> i_ready=d_ready=0, sram_w_en=0; after release with no requests -> both rvalids stay 0.
- Single fetch: i_req=1, i_addr=0x0010, SRAM[0x0010]=0x00500093 -> i_ready=1 in cycle N; i_rvalid=1 and i_rdata=0x00500093 in cycle N+1; d_rvalid=0.
- Conflict priority: i_req=d_req=1, d_addr=0x0100 read -> d_ready=1, i_ready=0; d_rvalid next cycle; starve_cnt=1.
- Starvation: both requesting continuously with STARVE_MAX=4 -> data granted cycles 0-3, fetch cycle 4, data cycles 5-8, fetch cycle 9 (period 5).
- Store: d_req=1, d_w_en=4'b0011, d_addr=0x0200, d_wdata=0xDEADBEEF -> sram_w_en=4'b0011 for one cycle, no d_rvalid; a later read of 0x0200 returns low half 0xBEEF.
- Reset mid-read: fetch granted, rst pulled low before the next edge -> i_rvalid=0 during reset and after release; with MEM_ARB_PERF_EN, conflict_cnt reads 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

    // Who owns the read data returning from the SRAM next cycle.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        I    = 2'd1,
        D    = 2'd2
    } owner_e;

    localparam int DEF_AW       = 16;
    localparam int DEF_DW       = 32;
    localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: counts consecutive cycles in which fetch is requesting but
// not granted. force_i goes high once the count reaches STARVE_MAX, so fetch
// wins the next conflict. That grant clears the count.
module arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic i_ready,
    output logic force_i
);

    localparam logic [STARVE_CNT_W-1:0] CNT_MAX = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] cnt;

    // Saturating count of denied fetch cycles; any grant or idle cycle clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (i_req && !i_ready)
            cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        else
            cnt <= '0;
    end

    assign force_i = (cnt == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous SRAM between instruction
// fetch (I) and load/store (D). Data has priority. The starvation counter
// forces a fetch grant after STARVE_MAX denied cycles. Read data returns
// one cycle after the grant and is steered by the registered owner.
// Optional: define MEM_ARB_PERF_EN to add the conflict_cnt output.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ready,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic [3:0]    d_w_en,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [3:0]    sram_w_en,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdata,
    input  logic [DW-1:0] sram_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]   conflict_cnt
`endif
);

    logic          force_i;
    logic          grant_i;
    logic          grant_d;
    owner_e        owner;
    owner_e        owner_nxt;
    logic [AW-1:0] last_addr;

    arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_ready (i_ready),
        .force_i (force_i)
    );

    // Same-cycle grant. Reset blocks both grants so nothing reaches the SRAM.
    always_comb begin
        grant_i = rst & i_req & (~d_req | force_i);
        grant_d = rst & d_req & ~grant_i;
    end

    assign i_ready = grant_i;
    assign d_ready = grant_d;

    // Steer the winner onto the SRAM. With no grant the address holds its last value.
    always_comb begin
        sram_w_en  = '0;
        sram_addr  = last_addr;
        sram_wdata = d_wdata;
        owner_nxt  = NONE;
        if (grant_i) begin
            sram_addr = i_addr;
            owner_nxt = I;
        end else if (grant_d) begin
            sram_addr = d_addr;
            sram_w_en = d_w_en;
            if (d_w_en == 4'b0000)
                owner_nxt = D;
        end
    end

    // Record the read owner and the last driven address. Reset drops any read in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner     <= NONE;
            last_addr <= '0;
        end else begin
            owner <= owner_nxt;
            if (grant_i || grant_d)
                last_addr <= sram_addr;
        end
    end

    assign i_rvalid = (owner == I);
    assign d_rvalid = (owner == D);
    assign i_rdata  = sram_rdata;
    assign d_rdata  = sram_rdata;

`ifdef MEM_ARB_PERF_EN
    // Saturating count of cycles in which both requesters competed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            conflict_cnt <= '0;
        else if (i_req && d_req && (conflict_cnt != 32'hFFFF_FFFF))
            conflict_cnt <= conflict_cnt + 32'd1;
    end
`endif

endmodule
